// File: rtl/pattern_sequencer.sv
// Pattern sequencer: plays rows from on-chip RAM as tracker notes, one row per tempo period.
// Define PATTERN_LOOP_EN to wrap from the last row back to row 0 instead of stopping.
module pattern_sequencer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int VOL_W  = 4,
    parameter int ROW_W  = 4 + 2 + VOL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ROW_W-1:0]  wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [7:0]        tempo,
    input  logic [ADDR_W-1:0] len,
    output logic [VOL_W-1:0]  note_volume,
    output logic [1:0]        note_instrument,
    output logic [3:0]        speed,
    output logic [ADDR_W-1:0] row,
    output logic              row_stb,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY
    } state_t;

    state_t state, state_nx;

    logic [ROW_W-1:0]  mem [DEPTH];
    logic [ROW_W-1:0]  data_q;
    logic [ADDR_W-1:0] row_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        cnt;
    logic [7:0]        tempo_q;
    logic [7:0]        tempo_ld;
    logic [7:0]        period;
    logic              rd_en;
    logic              mute;
    logic              mute_set;
    logic              done_nx;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        rd_addr  = row_q + ADDR_W'(1);
        done_nx  = 1'b0;
        mute_set = 1'b0;
        if (stop) begin
            state_nx = IDLE;
            mute_set = 1'b1;
        end else if (start) begin
            state_nx = FETCH;
        end else begin
            unique case (state)
                IDLE: begin
                end
                FETCH: begin
                    rd_en    = 1'b1;
                    rd_addr  = '0;
                    state_nx = PLAY;
                end
                PLAY: begin
                    // Last cycle of the row: prefetch so the next row lands without a bubble
                    if (!pause && cnt == 8'd0) begin
                        if (row_q == last_q) begin
`ifdef PATTERN_LOOP_EN
                            rd_en   = 1'b1;
                            rd_addr = '0;
`else
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                            mute_set = 1'b1;
`endif
                        end else begin
                            rd_en = 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Row 0 uses the tempo captured at start; later rows take the live value
    assign tempo_ld = (state == FETCH) ? tempo_q : tempo;
    assign period   = (tempo_ld == 8'd0) ? 8'd1 : tempo_ld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            data_q  <= '0;
            row_q   <= '0;
            last_q  <= '0;
            cnt     <= '0;
            tempo_q <= '0;
            mute    <= 1'b1;
            row_stb <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            row_stb <= rd_en;
            done    <= done_nx;
            if (start && !stop) begin
                last_q  <= len - ADDR_W'(1);
                tempo_q <= tempo;
            end
            if (rd_en) begin
                data_q <= mem[rd_addr];
                row_q  <= rd_addr;
                cnt    <= period - 8'd1;
                mute   <= 1'b0;
            end else if (mute_set) begin
                mute <= 1'b1;
            end else if (state == PLAY && !pause && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    assign note_volume     = mute ? '0 : data_q[VOL_W-1:0];
    assign note_instrument = data_q[VOL_W+1:VOL_W];
    assign speed           = data_q[ROW_W-1:ROW_W-4];
    assign row             = row_q;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: cycle-vector table plus directed pause/loop/rewrite sequences.
// Follows PATTERN_LOOP_EN to select expectations for the looping build.
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [9:0] wr_data;
    logic       start;
    logic       stop;
    logic       pause;
    logic [7:0] tempo;
    logic [3:0] len;
    logic [3:0] note_volume;
    logic [1:0] note_instrument;
    logic [3:0] speed;
    logic [3:0] row;
    logic       row_stb;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    pattern_sequencer dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .stop(stop),
        .pause(pause),
        .tempo(tempo),
        .len(len),
        .note_volume(note_volume),
        .note_instrument(note_instrument),
        .speed(speed),
        .row(row),
        .row_stb(row_stb),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        sp;
        logic        pa;
        logic [7:0]  te;
        logic [3:0]  ln;
        logic [16:0] exp;
        logic        cd;
    } vec_t;

    vec_t vq[$];

    function automatic logic [9:0] mk(input int s, input int i, input int v);
        return {4'(s), 2'(i), 4'(v)};
    endfunction

    function automatic void add(input logic st, input logic sp, input logic pa,
                                input int te, input int ln,
                                input logic stb, input logic bz, input logic dn,
                                input int vol, input int ins, input int spd,
                                input int rw, input logic cd);
        vec_t e;
        e.st  = st;
        e.sp  = sp;
        e.pa  = pa;
        e.te  = 8'(te);
        e.ln  = 4'(ln);
        e.exp = {stb, bz, dn, 4'(vol), 2'(ins), 4'(spd), 4'(rw)};
        e.cd  = cd;
        vq.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic wr(input int a, input logic [9:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    logic [16:0] got;
    logic [16:0] mask;
    int          stb_at[16];
    int          stb_cnt;
    int          done_cnt;
    int          done_at;
    int          prev;
    int          bad;
    logic        wrapped;

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        tempo = 8'd3;
        len = 4'd4;
        tick();
        tick();
        chk("reset_outputs",
            int'({row_stb, busy, done, note_volume, note_instrument, speed, row}), 0);
        rst = 1'b0;
        tick();

        wr(0, mk(1, 0, 15));
        wr(1, mk(2, 1, 8));
        wr(2, mk(1, 2, 4));
        wr(3, mk(3, 3, 1));
        for (int a = 4; a < 16; a++) begin
            wr(a, mk(a % 16, a % 4, 16 - a));
        end

        // single pattern, tempo 3, len 4
        add(1, 0, 0, 3, 4, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 3, 4, 1, 1, 0, 15, 0, 1, 0, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 15, 0, 1, 0, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 15, 0, 1, 0, 1);
        add(0, 0, 0, 3, 4, 1, 1, 0, 8, 1, 2, 1, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 8, 1, 2, 1, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 8, 1, 2, 1, 1);
        add(0, 0, 0, 3, 4, 1, 1, 0, 4, 2, 1, 2, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 4, 2, 1, 2, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 4, 2, 1, 2, 1);
        add(0, 0, 0, 3, 4, 1, 1, 0, 1, 3, 3, 3, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 1, 3, 3, 3, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 1, 3, 3, 3, 1);
`ifdef PATTERN_LOOP_EN
        add(0, 0, 0, 3, 4, 1, 1, 0, 15, 0, 1, 0, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 15, 0, 1, 0, 1);
`else
        add(0, 0, 0, 3, 4, 0, 0, 1, 0, 3, 3, 3, 1);
        add(0, 0, 0, 3, 4, 0, 0, 0, 0, 3, 3, 3, 1);
`endif
        add(0, 1, 0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0);

        // tempo 0 behaves as 1
        add(1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2, 1, 1, 0, 15, 0, 1, 0, 1);
        add(0, 0, 0, 0, 2, 1, 1, 0, 8, 1, 2, 1, 1);
`ifdef PATTERN_LOOP_EN
        add(0, 0, 0, 0, 2, 1, 1, 0, 15, 0, 1, 0, 1);
        add(0, 0, 0, 0, 2, 1, 1, 0, 8, 1, 2, 1, 1);
`else
        add(0, 0, 0, 0, 2, 0, 0, 1, 0, 1, 2, 1, 1);
        add(0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 2, 1, 1);
`endif
        add(0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);

        // stop one cycle after row 2 strobe, then start+stop together
        add(1, 0, 0, 3, 4, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3, 4, 1, 1, 0, 15, 0, 1, 0, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 15, 0, 1, 0, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 15, 0, 1, 0, 1);
        add(0, 0, 0, 3, 4, 1, 1, 0, 8, 1, 2, 1, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 8, 1, 2, 1, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 8, 1, 2, 1, 1);
        add(0, 0, 0, 3, 4, 1, 1, 0, 4, 2, 1, 2, 1);
        add(0, 0, 0, 3, 4, 0, 1, 0, 4, 2, 1, 2, 1);
        add(0, 1, 0, 3, 4, 0, 0, 0, 0, 2, 1, 2, 1);
        add(0, 0, 0, 3, 4, 0, 0, 0, 0, 2, 1, 2, 1);
        add(1, 1, 0, 3, 4, 0, 0, 0, 0, 2, 1, 2, 1);
        add(0, 0, 0, 3, 4, 0, 0, 0, 0, 2, 1, 2, 1);
        add(0, 0, 0, 3, 4, 0, 0, 0, 0, 2, 1, 2, 1);

        foreach (vq[i]) begin
            start = vq[i].st;
            stop  = vq[i].sp;
            pause = vq[i].pa;
            tempo = vq[i].te;
            len   = vq[i].ln;
            tick();
            got  = {row_stb, busy, done, note_volume, note_instrument, speed, row};
            mask = vq[i].cd ? 17'h1ffff : 17'h1fc00;
            checks++;
            if ((got & mask) !== (vq[i].exp & mask)) begin
                errors++;
                $display("FAIL vec%0d got=%05h expected=%05h mask=%05h",
                         i, got, vq[i].exp, mask);
            end
        end
        start = 1'b0;
        stop = 1'b0;

        // pause for 5 cycles in the middle of row 1
        foreach (stb_at[i]) stb_at[i] = -1;
        tempo = 8'd4;
        len = 4'd4;
        for (int k = 0; k <= 16; k++) begin
            start = (k == 0);
            pause = (k >= 7 && k <= 11);
            tick();
            if (row_stb) stb_at[row] = k + 1;
            if (k + 1 == 11) begin
                chk("pause_hold_row", int'(row), 1);
                chk("pause_hold_vol", int'(note_volume), 8);
                chk("pause_no_stb", int'(row_stb), 0);
            end
        end
        start = 1'b0;
        pause = 1'b0;
        chk("pause_row0_stb", stb_at[0], 2);
        chk("pause_row1_stb", stb_at[1], 6);
        chk("pause_row2_stb", stb_at[2], 15);
        halt();

        // len 0 plays all 16 rows
        tempo = 8'd1;
        len = 4'd0;
        stb_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        prev = 15;
        bad = 0;
        wrapped = 1'b0;
        for (int k = 0; k <= 41; k++) begin
            start = (k == 0);
            tick();
            if (done) begin
                done_cnt++;
                done_at = k + 1;
            end
            if (row_stb) begin
                stb_cnt++;
                if (int'(row) != (prev + 1) % 16) bad++;
                if (prev == 15 && row == 4'd0 && stb_cnt > 1) wrapped = 1'b1;
                prev = int'(row);
            end
        end
        start = 1'b0;
        chk("len0_row_order", bad, 0);
`ifdef PATTERN_LOOP_EN
        chk("loop_stb_count", stb_cnt, 41);
        chk("loop_no_done", done_cnt, 0);
        chk("loop_wrapped", int'(wrapped), 1);
        chk("loop_busy", int'(busy), 1);
`else
        chk("len0_stb_count", stb_cnt, 16);
        chk("len0_done_count", done_cnt, 1);
        chk("len0_done_cycle", done_at, 18);
        chk("len0_last_row", int'(row), 15);
`endif
        halt();

        // rewrite row 3 during playback, then restart while busy
        tempo = 8'd2;
        len = 4'd4;
        for (int k = 0; k <= 12; k++) begin
            start   = (k == 0 || k == 9);
            wr_en   = (k == 4);
            wr_addr = 4'd3;
            wr_data = mk(5, 2, 9);
            tick();
            if (k + 1 == 4) chk("rw_row1_stb", int'({row_stb, row}), 16 + 1);
            if (k + 1 == 8) begin
                chk("rw_row3_stb", int'({row_stb, row}), 16 + 3);
                chk("rw_row3_data", int'({speed, note_instrument, note_volume}),
                    int'(mk(5, 2, 9)));
            end
            if (k + 1 == 10) begin
                chk("restart_fetch", int'({row_stb, busy, done}), 2);
            end
            if (k + 1 == 11) begin
                chk("restart_row0", int'({row_stb, busy, row}), 32 + 16);
                chk("restart_vol", int'(note_volume), 15);
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        halt();
        chk("final_idle", int'({busy, note_volume}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
